class_argmax: RTL and testbench

Streaming arg-max stage that sits directly downstream of the fp16-to-integer converter at the classifier output. It consumes one 16-bit unsigned integer score per class per frame. It tracks the running maximum and its class index. At frame end it presents the winning class and score on a valid/ready output port. Frame boundaries come from an internal sample counter and are cross-checked against an upstream `in_last` marker.

---
 rtl/class_argmax.sv | 99 +++++++++
 tb/tb_class_argmax.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/class_argmax.sv
// class_argmax: streaming arg-max over one frame of unsigned class scores.
// Emits winning class/score on a valid/ready port; flags frame-length mismatches.
module class_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_class,
  output logic [DATA_W-1:0] out_score,
  output logic              frame_err
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t              state_q;
  logic [IDX_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   max_score_q;
  logic [DATA_W-1:0]   max_score_d;
  logic [IDX_W-1:0]    max_idx_q;
  logic [IDX_W-1:0]    max_idx_d;
  logic                out_valid_q;
  logic [IDX_W-1:0]    out_class_q;
  logic [DATA_W-1:0]   out_score_q;
  logic                frame_err_q;
  logic                frame_err_d;
  logic                accept;
  logic                at_end;
  logic                take;
  logic                close;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_score = out_score_q;
  assign frame_err = frame_err_q;

  // First sample of a frame always loads; later ones need strictly greater.
  always_comb begin
    accept      = in_valid && in_ready;
    at_end      = (cnt_q == LAST_IDX);
    take        = (cnt_q == '0) || (in_data > max_score_q);
    max_score_d = take ? in_data : max_score_q;
    max_idx_d   = take ? cnt_q : max_idx_q;
    close       = accept && (at_end || in_last);
    frame_err_d = close && (at_end ^ in_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      max_score_q <= '0;
      max_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            max_score_q <= max_score_d;
            max_idx_q   <= max_idx_d;
            if (close) begin
              out_class_q <= max_idx_d;
              out_score_q <= max_score_d;
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= HOLD;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_class_argmax.sv
// Bench for class_argmax: directed and random frames checked
// against an arg-max reference computed over the sent scores.
module tb_class_argmax;

  localparam int N = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_class;
  logic [15:0] out_score;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int sc [16];

  class_argmax #(.NUM_CLASSES(N), .IDX_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_score(out_score), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: index of first occurrence of the largest value.
  function automatic void ref_max(input int n, output int idx,
                                  output int best);
    idx  = 0;
    best = sc[0];
    for (int i = 1; i < n; i++)
      if (sc[i] > best) begin
        best = sc[i];
        idx  = i;
      end
  endfunction

  task automatic feed(input int n, input bit mark, input int gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps > 0) begin
        int g = $urandom_range(0, gaps);
        in_valid = 1'b0;
        for (int k = 0; k < g; k++) tick();
      end
      in_valid = 1'b1;
      in_data  = 16'(sc[i]);
      in_last  = mark && (i == n - 1);
      chk("in_ready_accum", 32'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input int n, input bit err);
    int idx, best;
    ref_max(n, idx, best);
    chk("out_valid", 32'(out_valid), 1);
    chk("out_class", 32'(out_class), 32'(idx));
    chk("out_score", 32'(out_score), 32'(best));
    chk("frame_err", 32'(frame_err), 32'(err));
    chk("in_ready_hold", 32'(in_ready), 0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    chk("out_valid_clr", 32'(out_valid), 0);
    chk("frame_err_clr", 32'(frame_err), 0);
    chk("in_ready_back", 32'(in_ready), 1);
  endtask

  task automatic frame(input int n, input bit mark, input int gaps,
                       input bit err);
    feed(n, mark, gaps);
    check_result(n, err);
    handshake();
  endtask

  initial begin
    int hold_cls, hold_sc;
    int ties [10] = '{3, 7, 2, 9, 9, 1, 0, 4, 5, 8};

    // Reset state
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_class", 32'(out_class), 0);
    chk("rst_score", 32'(out_score), 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_ready", 32'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Ties keep lowest index
    for (int i = 0; i < N; i++) sc[i] = ties[i];
    frame(N, 1'b1, 0, 1'b0);

    // Zeros then top-of-range, back to back
    for (int i = 0; i < N; i++) sc[i] = 0;
    frame(N, 1'b1, 0, 1'b0);
    sc[9] = 65535;
    frame(N, 1'b1, 0, 1'b0);

    // Backpressure with ignored samples
    for (int i = 0; i < N; i++) sc[i] = $urandom_range(0, 50000);
    out_ready = 1'b0;
    feed(N, 1'b1, 0);
    check_result(N, 1'b0);
    hold_cls = int'(out_class);
    hold_sc  = int'(out_score);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 16'd60000;
      in_last  = 1'b1;
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_class", 32'(out_class), 32'(hold_cls));
      chk("bp_score", 32'(out_score), 32'(hold_sc));
      chk("bp_ready", 32'(in_ready), 0);
      chk("bp_err", 32'(frame_err), 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    handshake();
    for (int i = 0; i < N; i++) sc[i] = $urandom_range(0, 1000);
    frame(N, 1'b1, 0, 1'b0);

    // Short frame and missing marker
    for (int i = 0; i < 5; i++) sc[i] = i + 1;
    frame(5, 1'b1, 0, 1'b1);
    for (int i = 0; i < N; i++) sc[i] = $urandom_range(0, 65535);
    frame(N, 1'b0, 0, 1'b1);

    // Reset mid-frame
    for (int i = 0; i < 6; i++) sc[i] = 65000 + i;
    feed(6, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_class", 32'(out_class), 0);
    chk("mrst_score", 32'(out_score), 0);
    chk("mrst_err", 32'(frame_err), 0);
    chk("mrst_ready", 32'(in_ready), 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) sc[i] = $urandom_range(0, 60000);
    frame(N, 1'b1, 0, 1'b0);

    // Stalled frame, then the same scores unstalled
    for (int i = 0; i < N; i++) sc[i] = $urandom_range(0, 7);
    frame(N, 1'b1, 3, 1'b0);
    frame(N, 1'b1, 0, 1'b0);

    // Random frames: mixed lengths, narrow ranges for ties
    for (int f = 0; f < 30; f++) begin
      int n   = $urandom_range(2, N);
      int top = ($urandom_range(0, 1) == 1) ? 3 : 65535;
      bit mk  = (n < N) ? 1'b1 : 1'(($urandom_range(0, 3) != 0));
      bit er  = (n < N) || !mk;
      for (int i = 0; i < n; i++) sc[i] = $urandom_range(0, top);
      frame(n, mk, $urandom_range(0, 2), er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
